// File: rtl/ps2_key_decoder_if.sv
// Groups the scan-code byte stream into the decoder and the decoded key outputs back out.
// Latency: none, wires only.
// Backpressure: none; the byte source never waits and every strobed byte is consumed.
interface ps2_key_decoder_if;
   logic [7:0] received_data;
   logic       received_en;
   logic       clear_all;
   logic [4:0] key_hold;
   logic [4:0] key_press;
   logic [7:0] last_code;
   logic       last_ext;
   logic       code_valid;

   // Byte source side: PS2_Controller feeding bytes, game logic consuming key state
   modport master (
      output received_data, received_en, clear_all,
      input  key_hold, key_press, last_code, last_ext, code_valid
   );

   // Decoder side
   modport slave (
      input  received_data, received_en, clear_all,
      output key_hold, key_press, last_code, last_ext, code_valid
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// Decodes PS/2 set-2 scan codes (E0/F0 prefixes) into held levels and press pulses for W/A/S/D, arrows, Space.
// Latency: all outputs change on the same clock edge that samples the received_en strobe.
// Backpressure: none; every strobed byte is consumed, clear_all wins over a same-cycle byte.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic              clock,
   input  logic              resetn,
   ps2_key_decoder_if.slave  kif
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  NO_KEY   = 4'hF;

   // Held-flag slots: even = letter/space source, odd = extended arrow source
   //   0 W, 1 Up, 2 S, 3 Down, 4 A, 5 Left, 6 D, 7 Right, 8 Space

   // Controller replies that are never keys
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

   function automatic logic [3:0] key_idx(input logic [7:0] c, input logic ext);
      logic [3:0] idx;
      idx = NO_KEY;
      if (!ext) begin
         case (c)
            8'h1D:   idx = 4'd0;
            8'h1B:   idx = 4'd2;
            8'h1C:   idx = 4'd4;
            8'h23:   idx = 4'd6;
            8'h29:   idx = 4'd8;
            default: idx = NO_KEY;
         endcase
      end else begin
         case (c)
            8'h75:   idx = 4'd1;
            8'h72:   idx = 4'd3;
            8'h6B:   idx = 4'd5;
            8'h74:   idx = 4'd7;
            default: idx = NO_KEY;
         endcase
      end
      return idx;
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic [8:0]    flags_q, flags_d;
   logic [4:0]    key_hold_q, key_hold_d;
   logic [4:0]    key_press_q, key_press_d;
   logic [7:0]    last_code_q, last_code_d;
   logic          last_ext_q, last_ext_d;
   logic          code_valid_q, code_valid_d;
   logic [3:0]    idx;
   logic          byte_e0, byte_f0, byte_ign, ext_ctx;

   // Register all state and outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         tmo_q        <= '0;
         flags_q      <= '0;
         key_hold_q   <= '0;
         key_press_q  <= '0;
         last_code_q  <= '0;
         last_ext_q   <= 1'b0;
         code_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         flags_q      <= flags_d;
         key_hold_q   <= key_hold_d;
         key_press_q  <= key_press_d;
         last_code_q  <= last_code_d;
         last_ext_q   <= last_ext_d;
         code_valid_q <= code_valid_d;
      end
   end

   // Prefix FSM, prefix timeout, make/break bookkeeping and output derivation
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      flags_d      = flags_q;
      last_code_d  = last_code_q;
      last_ext_d   = last_ext_q;
      code_valid_d = 1'b0;
      byte_e0      = (kif.received_data == 8'hE0);
      byte_f0      = (kif.received_data == 8'hF0);
      byte_ign     = is_ignored(kif.received_data);
      ext_ctx      = (state_q == EXT) || (state_q == EXT_BRK);
      idx          = key_idx(kif.received_data, ext_ctx);

      if (kif.clear_all) begin
         state_d = IDLE;
         tmo_d   = '0;
         flags_d = '0;
      end else if (kif.received_en) begin
         tmo_d = '0;
         unique case (state_q)
            IDLE, EXT: begin
               if (byte_f0) begin
                  state_d = (state_q == EXT) ? EXT_BRK : BRK;
               end else if (byte_e0) begin
                  state_d = EXT;
               end else begin
                  state_d = IDLE;
                  if (!byte_ign) begin
                     // Completed make: report it even if it maps to no game key
                     code_valid_d = 1'b1;
                     last_code_d  = kif.received_data;
                     last_ext_d   = ext_ctx;
                     if (idx != NO_KEY) flags_d[idx] = 1'b1;
                  end
               end
            end
            BRK, EXT_BRK: begin
               // A stray prefix or reply after F0 aborts the break silently
               state_d = IDLE;
               if (!byte_e0 && !byte_f0 && !byte_ign && idx != NO_KEY) flags_d[idx] = 1'b0;
            end
         endcase
      end else if (state_q != IDLE) begin
         if (tmo_q == TMO_LAST) begin
            state_d = IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + CW'(1);
         end
      end

      key_hold_d  = {flags_d[8], flags_d[6] | flags_d[7], flags_d[4] | flags_d[5],
                     flags_d[2] | flags_d[3], flags_d[0] | flags_d[1]};
      key_press_d = key_hold_d & ~key_hold_q;
   end

   assign kif.key_hold   = key_hold_q;
   assign kif.key_press  = key_press_q;
   assign kif.last_code  = last_code_q;
   assign kif.last_ext   = last_ext_q;
   assign kif.code_valid = code_valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench: directed scenarios plus random byte streams against a key-set reference model.
// Latency: model predicts outputs one edge after each driven byte.
// Backpressure: none; bytes are driven freely, clear/reset injected at random.
module tb_ps2_key_decoder;

   localparam int T = 16;

   logic clk;
   logic rst_n;
   ps2_key_decoder_if kif ();

   ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clock  (clk),
      .resetn (rst_n),
      .kif    (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_press = 0;
   int n_cv    = 0;

   // Reference model: set of currently made keys keyed by {ext, code}, pending prefixes, idle count
   bit         held[int];
   bit         m_e0, m_f0;
   int         m_idle;
   logic [4:0] m_hold, m_press;
   logic [7:0] m_code;
   logic       m_ext, m_cv;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] hold_of();
      logic [4:0] h;
      h[0] = held.exists('h01D) || held.exists('h175);
      h[1] = held.exists('h01B) || held.exists('h172);
      h[2] = held.exists('h01C) || held.exists('h16B);
      h[3] = held.exists('h023) || held.exists('h174);
      h[4] = held.exists('h029);
      return h;
   endfunction

   function automatic bit reply_byte(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   endfunction

   task automatic model_reset();
      held.delete();
      m_e0 = 0; m_f0 = 0; m_idle = 0;
      m_hold = '0; m_press = '0; m_code = '0; m_ext = 0; m_cv = 0;
   endtask

   task automatic model_step(input bit en, input logic [7:0] d, input bit clr);
      logic [4:0] nh;
      m_cv = 0;
      if (clr) begin
         held.delete();
         m_e0 = 0; m_f0 = 0; m_idle = 0;
      end else if (en) begin
         m_idle = 0;
         if (reply_byte(d)) begin
            m_e0 = 0; m_f0 = 0;
         end else if (d == 8'hE0 || d == 8'hF0) begin
            if (m_f0) begin
               m_e0 = 0; m_f0 = 0;
            end else if (d == 8'hE0) begin
               m_e0 = 1;
            end else begin
               m_f0 = 1;
            end
         end else begin
            if (m_f0) begin
               if (held.exists(int'(m_e0) * 256 + int'(d))) held.delete(int'(m_e0) * 256 + int'(d));
            end else begin
               held[int'(m_e0) * 256 + int'(d)] = 1;
               m_cv = 1; m_code = d; m_ext = m_e0;
            end
            m_e0 = 0; m_f0 = 0;
         end
      end else if (m_e0 || m_f0) begin
         m_idle++;
         if (m_idle == T) begin
            m_e0 = 0; m_f0 = 0; m_idle = 0;
         end
      end
      nh      = hold_of();
      m_press = nh & ~m_hold;
      m_hold  = nh;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".hold"},  16'(kif.key_hold),   16'(m_hold));
      chk({tag, ".press"}, 16'(kif.key_press),  16'(m_press));
      chk({tag, ".cv"},    16'(kif.code_valid), 16'(m_cv));
      chk({tag, ".code"},  16'(kif.last_code),  16'(m_code));
      chk({tag, ".ext"},   16'(kif.last_ext),   16'(m_ext));
      if (kif.key_press != '0) n_press++;
      if (kif.code_valid) n_cv++;
   endtask

   // One clock: drive at negedge, model at posedge, check at next negedge
   task automatic cycle(input bit en, input logic [7:0] d, input bit clr);
      kif.received_en   = en;
      kif.received_data = d;
      kif.clear_all     = clr;
      @(posedge clk);
      model_step(en, d, clr);
      @(negedge clk);
      kif.received_en = 1'b0;
      kif.clear_all   = 1'b0;
      check_outputs("cyc");
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("rst_async");
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outputs("rst_hold");
      end
      rst_n = 1'b1;
   endtask

   logic [7:0] pool [18] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74,
                             8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hFA, 8'hAA, 8'h00, 8'hE1, 8'h16};

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [7:0] b;
      rst_n             = 1'b0;
      kif.received_en   = 1'b0;
      kif.received_data = 8'h00;
      kif.clear_all     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // W make then break
      send(8'h1D);
      chk("w_hold",  16'(kif.key_hold),  16'h0001);
      chk("w_press", 16'(kif.key_press), 16'h0001);
      chk("w_code",  16'(kif.last_code), 16'h001D);
      send(8'hF0);
      send(8'h1D);
      chk("w_rel_hold", 16'(kif.key_hold),   16'h0000);
      chk("w_rel_cv",   16'(kif.code_valid), 16'h0000);

      // Up arrow and W overlap: one press pulse only
      n_press = 0;
      send(8'hE0); send(8'h75);
      send(8'h1D);
      send(8'hF0); send(8'h1D);
      chk("up_keep", 16'(kif.key_hold), 16'h0001);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("up_rel", 16'(kif.key_hold), 16'h0000);
      chk("up_npress", 16'(n_press), 16'd1);

      // Typematic repeat of Space
      n_press = 0; n_cv = 0;
      repeat (5) send(8'h29);
      chk("sp_hold",   16'(kif.key_hold),  16'h0010);
      chk("sp_npress", 16'(n_press),       16'd1);
      chk("sp_ncv",    16'(n_cv),          16'd5);
      chk("sp_code",   16'(kif.last_code), 16'h0029);
      send(8'hF0); send(8'h29);

      // Prefix timeout: 72 decodes as non-extended
      send(8'hE0);
      idle(T);
      send(8'h72);
      chk("tmo_hold", 16'(kif.key_hold),  16'h0000);
      chk("tmo_code", 16'(kif.last_code), 16'h0072);
      chk("tmo_ext",  16'(kif.last_ext),  16'h0000);

      // clear_all beats a same-cycle byte
      send(8'h1C); send(8'h23);
      n_press = 0;
      cycle(1'b1, 8'h1D, 1'b1);
      chk("clr_hold",   16'(kif.key_hold),  16'h0000);
      chk("clr_npress", 16'(n_press),       16'd0);
      chk("clr_code",   16'(kif.last_code), 16'h0023);

      // Reset after E0
      send(8'hE0);
      do_reset(3);
      @(negedge clk);
      send(8'h6B);
      chk("rst_hold2", 16'(kif.key_hold),  16'h0000);
      chk("rst_code",  16'(kif.last_code), 16'h006B);
      chk("rst_ext",   16'(kif.last_ext),  16'h0000);

      // Reply byte aborts a break
      send(8'hF0); send(8'hFA); send(8'h1C);
      chk("fa_hold", 16'(kif.key_hold), 16'h0004);
      cycle(1'b0, 8'h00, 1'b1);

      // Random streams with clears, resets and prefix timeouts near the boundary
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 99);
         b = pool[$urandom_range(0, 17)];
         if (r < 2)       cycle(1'b0, 8'h00, 1'b1);
         else if (r < 3)  cycle(1'b1, b, 1'b1);
         else if (r < 4) begin
            do_reset($urandom_range(1, 3));
            @(negedge clk);
         end else if (r < 7) idle($urandom_range(T - 2, T + 1));
         else             cycle($urandom_range(0, 9) < 6, b, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
